// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources.
// Ports: clk, reset (sync, active-high); req/req_data/req_ack per requester;
// tx_en/tx_data/tx_busy to the transmitter; grant_id, arb_busy, timeout_err.
// Optional: UART_ARB_LOCK_EN adds req_lock to hold the grant across a frame.
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int PAYLOAD_BITS  = 8,
  parameter int START_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*PAYLOAD_BITS-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [N_REQ-1:0]              req_lock,
`endif
  output logic [N_REQ-1:0]              req_ack,
  output logic                          tx_en,
  output logic [PAYLOAD_BITS-1:0]       tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          arb_busy,
  output logic                          timeout_err
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           grant_q;
  logic [PAYLOAD_BITS-1:0] tx_data_q;
  logic [CW-1:0]           cnt_q;

  logic [GW-1:0]           win;
  logic                    found;
  int                      idx;

  // grant_q doubles as the round-robin pointer: it only changes on a
  // launch, so in IDLE it always equals the last granted requester.
  always_comb begin
    win   = grant_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(grant_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
`ifdef UART_ARB_LOCK_EN
    if (req[grant_q] && req_lock[grant_q]) begin
      found = 1'b1;
      win   = grant_q;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    tx_en       = 1'b0;
    req_ack     = '0;
    timeout_err = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found && !tx_busy) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        tx_en            = 1'b1;
        req_ack[grant_q] = 1'b1;
        state_d          = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(START_TIMEOUT)) begin
          timeout_err = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= GW'(N_REQ - 1);
      tx_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && state_d == S_LAUNCH) begin
        grant_q   <= win;
        tx_data_q <= req_data[int'(win)*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
      if (state_q == S_LAUNCH) begin
        cnt_q <= '0;
      end else if (state_q == S_WAIT_BUSY) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign grant_id = grant_q;
  assign tx_data  = tx_data_q;
  assign arb_busy = (state_q != S_IDLE);

endmodule
